busca_instrucao: RTL and testbench

Instruction-fetch stage directly upstream of the multicycle control unit. Holds the program counter (CP) and instruction register (IR), fetches from instruction memory over a req/ack handshake, and presents the decoded `opcode` and operand fields to control and datapath. Redirects CP from the control outputs `EscCP`, `EscCondCP`, `FonteCP` and the ALU zero flag.

---
 rtl/busca_instrucao_pkg.sv | 30 +++
 rtl/busca_instrucao_if.sv | 24 ++
 rtl/busca_instrucao_registrador_cp.sv | 48 ++++
 rtl/busca_instrucao.sv | 108 ++++++++++
 tb/tb_busca_instrucao.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/busca_instrucao_pkg.sv
// rtl/busca_instrucao_pkg.sv - shared widths, encodings and IR field positions for the fetch stage
package busca_instrucao_pkg;

    localparam int LARG_CP    = 8;
    localparam int LARG_INSTR = 16;

    // Next-CP source select driven by the control unit
    localparam logic [1:0] FONTE_SEQ    = 2'b00;
    localparam logic [1:0] FONTE_DESVIO = 2'b01;
    localparam logic [1:0] FONTE_SALTO  = 2'b10;

    typedef enum logic [1:0] {
        OCIOSO = 2'b00,
        ESPERA = 2'b01,
        PRONTO = 2'b10
    } estado_t;

    // IR field bit positions
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int RD_MSB     = 11;
    localparam int RD_LSB     = 8;
    localparam int RS_MSB     = 7;
    localparam int RS_LSB     = 4;
    localparam int RT_MSB     = 3;
    localparam int RT_LSB     = 0;
    localparam int IMED_MSB   = 7;
    localparam int IMED_LSB   = 0;

endpackage

// File: rtl/busca_instrucao_if.sv
// rtl/busca_instrucao_if.sv - instruction-memory req/ack bus between fetch stage and memory
interface busca_instrucao_if;
    import busca_instrucao_pkg::*;

    logic                  mem_req;
    logic [LARG_CP-1:0]    mem_addr;
    logic                  mem_ack;
    logic [LARG_INSTR-1:0] mem_dado;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_dado
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_dado
    );

endinterface

// File: rtl/busca_instrucao_registrador_cp.sv
// rtl/busca_instrucao_registrador_cp.sv - program counter register with next-CP source mux
module registrador_cp
    import busca_instrucao_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_carrega,
    input  logic [1:0]         i_FonteCP,
    input  logic               i_EscCondCP,
    input  logic               i_zero,
    input  logic [LARG_CP-1:0] i_alvo_desvio,
    input  logic [7:0]         i_imediato,
    output logic [LARG_CP-1:0] o_cp
);

    logic [LARG_CP-1:0] r_cp;
    logic [LARG_CP-1:0] w_cp_mais_1;
    logic [LARG_CP-1:0] w_prox_cp;

    // Sequential increment wraps naturally at the register width
    assign w_cp_mais_1 = r_cp + LARG_CP'(1);

    // Select the next CP; unconditional or taken branches use the ALU target, reserved code falls back to sequential
    always_comb begin
        w_prox_cp = w_cp_mais_1;
        case (i_FonteCP)
            FONTE_DESVIO: begin
                if (!i_EscCondCP || i_zero) begin
                    w_prox_cp = i_alvo_desvio;
                end
            end
            FONTE_SALTO:  w_prox_cp = LARG_CP'(i_imediato);
            default:      w_prox_cp = w_cp_mais_1;
        endcase
    end

    // CP register, updated only when the fetch stage accepts a PC write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cp <= '0;
        end else if (i_carrega) begin
            r_cp <= w_prox_cp;
        end
    end

    assign o_cp = r_cp;

endmodule

// File: rtl/busca_instrucao.sv
// rtl/busca_instrucao.sv - instruction fetch stage: CP, IR, memory handshake and fetch counter
module busca_instrucao
    import busca_instrucao_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_EscCP,
    input  logic                  i_EscCondCP,
    input  logic [1:0]            i_FonteCP,
    input  logic                  i_zero,
    input  logic [LARG_CP-1:0]    i_alvo_desvio,
    busca_instrucao_if.master     bus,
    output logic [3:0]            o_opcode,
    output logic [3:0]            o_rd,
    output logic [3:0]            o_rs,
    output logic [3:0]            o_rt,
    output logic [7:0]            o_imediato,
    output logic [LARG_CP-1:0]    o_cp,
    output logic                  o_instr_valida,
    output logic [15:0]           o_num_buscas
);

    estado_t               r_estado;
    estado_t               w_prox_estado;
    logic                  r_mem_req;
    logic [LARG_INSTR-1:0] r_ir;
    logic                  r_instr_valida;
    logic [15:0]           r_num_buscas;
    logic                  w_aceita_ack;
    logic                  w_carrega_cp;
    logic [LARG_CP-1:0]    w_cp;

    registrador_cp u_registrador_cp (
        .clk           (clk),
        .rst           (rst),
        .i_carrega     (w_carrega_cp),
        .i_FonteCP     (i_FonteCP),
        .i_EscCondCP   (i_EscCondCP),
        .i_zero        (i_zero),
        .i_alvo_desvio (i_alvo_desvio),
        .i_imediato    (r_ir[IMED_MSB:IMED_LSB]),
        .o_cp          (w_cp)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox_estado;
        end
    end

    // Next state; acks count only while a request is outstanding, PC writes only once the IR is ready
    always_comb begin
        w_prox_estado = r_estado;
        w_aceita_ack  = 1'b0;
        w_carrega_cp  = 1'b0;
        case (r_estado)
            OCIOSO: w_prox_estado = ESPERA;
            ESPERA: begin
                if (r_mem_req && bus.mem_ack) begin
                    w_aceita_ack  = 1'b1;
                    w_prox_estado = PRONTO;
                end
            end
            PRONTO: begin
                if (i_EscCP) begin
                    w_carrega_cp  = 1'b1;
                    w_prox_estado = ESPERA;
                end
            end
            default: w_prox_estado = OCIOSO;
        endcase
    end

    // Request, IR, valid flag and fetch counter; IR moves only on an accepted ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_req      <= 1'b0;
            r_ir           <= '0;
            r_instr_valida <= 1'b0;
            r_num_buscas   <= '0;
        end else begin
            r_mem_req <= (w_prox_estado == ESPERA);
            if (w_aceita_ack) begin
                r_ir           <= bus.mem_dado;
                r_instr_valida <= 1'b1;
                r_num_buscas   <= r_num_buscas + 16'd1;
            end else if (w_carrega_cp) begin
                r_instr_valida <= 1'b0;
            end
        end
    end

    assign bus.mem_req  = r_mem_req;
    assign bus.mem_addr = w_cp;

    assign o_opcode       = r_ir[OPCODE_MSB:OPCODE_LSB];
    assign o_rd           = r_ir[RD_MSB:RD_LSB];
    assign o_rs           = r_ir[RS_MSB:RS_LSB];
    assign o_rt           = r_ir[RT_MSB:RT_LSB];
    assign o_imediato     = r_ir[IMED_MSB:IMED_LSB];
    assign o_cp           = w_cp;
    assign o_instr_valida = r_instr_valida;
    assign o_num_buscas   = r_num_buscas;

endmodule

// File: tb/tb_busca_instrucao.sv
// tb/tb_busca_instrucao.sv - scoreboard bench for busca_instrucao with random memory latency
module tb_busca_instrucao;
    import busca_instrucao_pkg::*;

    localparam int NTRANS = 150;

    logic        clk = 1'b0;
    logic        rst;
    logic        EscCP;
    logic        EscCondCP;
    logic [1:0]  FonteCP;
    logic        zero;
    logic [7:0]  alvo;
    logic [3:0]  opcode, rd, rs, rt;
    logic [7:0]  imediato;
    logic [7:0]  cp;
    logic        instr_valida;
    logic [15:0] num_buscas;

    busca_instrucao_if bus ();

    busca_instrucao dut (
        .clk            (clk),
        .rst            (rst),
        .i_EscCP        (EscCP),
        .i_EscCondCP    (EscCondCP),
        .i_FonteCP      (FonteCP),
        .i_zero         (zero),
        .i_alvo_desvio  (alvo),
        .bus            (bus),
        .o_opcode       (opcode),
        .o_rd           (rd),
        .o_rs           (rs),
        .o_rt           (rt),
        .o_imediato     (imediato),
        .o_cp           (cp),
        .o_instr_valida (instr_valida),
        .o_num_buscas   (num_buscas)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] instr;
        logic [15:0] cnt;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] mem [256];
    int          mem_mode = 0;   // 0 random latency, 1 never ack, 2 stray ack with junk
    logic [7:0]  cp_m;
    logic [15:0] cnt_m;

    logic        mon_prev_req = 1'b0;
    logic        mon_prev_val = 1'b0;
    logic        mon_active   = 1'b0;
    exp_t        mon_cur      = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic [7:0] a);
        exp_t e;
        cnt_m   = cnt_m + 16'd1;
        e.addr  = a;
        e.instr = mem[a];
        e.cnt   = cnt_m;
        q.push_back(e);
    endtask

    // Wait for a completed fetch, randomly pulsing EscCP while the fetch is outstanding
    task automatic wait_valida();
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #2;
            EscCP = 1'b0;
            if (instr_valida) return;
            if (bus.mem_req && ($urandom_range(0, 2) == 0)) begin
                EscCP   = 1'b1;
                FonteCP = 2'($urandom_range(0, 3));
                alvo    = 8'($urandom);
            end
        end
        check("timeout_instr_valida", 32'(instr_valida), 32'd1);
    endtask

    // Memory model: random wait states, stray acks with junk data when nothing is requested
    initial begin
        bus.mem_ack  = 1'b0;
        bus.mem_dado = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_mode == 1) begin
                bus.mem_ack = 1'b0;
            end else if (mem_mode == 2) begin
                bus.mem_ack  = 1'b1;
                bus.mem_dado = 16'($urandom);
            end else if (bus.mem_req) begin
                bus.mem_ack  = ($urandom_range(0, 1) == 0);
                bus.mem_dado = mem[bus.mem_addr];
            end else begin
                bus.mem_ack  = ($urandom_range(0, 3) == 0);
                bus.mem_dado = 16'($urandom);
            end
        end
    end

    // Monitor: pops an expectation at each new request, checks address stability and the loaded IR
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_prev_req = 1'b0;
                mon_prev_val = 1'b0;
                mon_active   = 1'b0;
            end else begin
                if (bus.mem_req && !mon_prev_req) begin
                    if (q.size() == 0) begin
                        check("request_without_expectation", 32'(q.size()), 32'd1);
                    end else begin
                        mon_cur    = q.pop_front();
                        mon_active = 1'b1;
                        check("mem_addr", 32'(bus.mem_addr), 32'(mon_cur.addr));
                    end
                end else if (bus.mem_req) begin
                    check("mem_addr_stable", 32'(bus.mem_addr), 32'(mon_cur.addr));
                end
                if (instr_valida && !mon_prev_val) begin
                    check("valid_after_request", 32'(mon_active), 32'd1);
                    check("ir_fields", 32'({opcode, rd, rs, rt}), 32'(mon_cur.instr));
                    check("imediato", 32'(imediato), 32'(mon_cur.instr[7:0]));
                    check("num_buscas", 32'(num_buscas), 32'(mon_cur.cnt));
                    mon_active = 1'b0;
                end else if (instr_valida) begin
                    check("ir_stable", 32'({opcode, rd, rs, rt}), 32'(mon_cur.instr));
                end
                mon_prev_req = bus.mem_req;
                mon_prev_val = instr_valida;
            end
        end
    end

    // Stimulus and reference model
    initial begin
        logic [1:0] d_f [6];
        logic       d_c [6];
        logic       d_z [6];
        logic [7:0] d_a [6];
        logic [1:0] f;
        logic       c, z;
        logic [7:0] a, nxt;

        d_f = '{2'd1, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
        d_c = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        d_z = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        d_a = '{8'hFF, 8'h00, 8'h40, 8'h40, 8'h00, 8'h00};

        rst = 1'b1; EscCP = 1'b0; EscCondCP = 1'b0; FonteCP = 2'd0; zero = 1'b0; alvo = 8'd0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[8'h00] = 16'h1234;
        mem[8'h41] = 16'hB0A7;

        #3;
        check("rst_cp", 32'(cp), 32'd0);
        check("rst_ir", 32'({opcode, rd, rs, rt, imediato}), 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_instr_valida", 32'(instr_valida), 32'd0);
        check("rst_num_buscas", 32'(num_buscas), 32'd0);

        cp_m  = 8'd0;
        cnt_m = 16'd0;
        push_exp(cp_m);

        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("req_in_ocioso", 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        check("req_after_reset", 32'(bus.mem_req), 32'd1);

        for (int t = 0; t < NTRANS; t++) begin
            wait_valida();
            check("cp", 32'(cp), 32'(cp_m));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #2;
            end
            if (t < 6) begin
                f = d_f[t]; c = d_c[t]; z = d_z[t]; a = d_a[t];
            end else begin
                f = 2'($urandom_range(0, 3)); c = 1'($urandom); z = 1'($urandom); a = 8'($urandom);
            end
            EscCP = 1'b1; FonteCP = f; EscCondCP = c; zero = z; alvo = a;
            if (f == 2'd1)      nxt = (!c || z) ? a : cp_m + 8'd1;
            else if (f == 2'd2) nxt = mem[cp_m][7:0];
            else                nxt = cp_m + 8'd1;
            cp_m = nxt;
            push_exp(cp_m);
            @(posedge clk); #2;
            EscCP = 1'b0;
        end
        wait_valida();
        check("cp_final", 32'(cp), 32'(cp_m));

        // Abort a fetch with reset, then present a stray ack right after release
        mem_mode = 1;
        EscCP = 1'b1; FonteCP = FONTE_SEQ;
        @(posedge clk); #2;
        EscCP = 1'b0;
        check("req_before_abort", 32'(bus.mem_req), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_mem_req", 32'(bus.mem_req), 32'd0);
        check("abort_cp", 32'(cp), 32'd0);
        check("abort_num_buscas", 32'(num_buscas), 32'd0);
        check("abort_ir", 32'({opcode, rd, rs, rt}), 32'd0);
        q.delete();
        mem_mode = 2;
        cp_m  = 8'd0;
        cnt_m = 16'd0;
        push_exp(cp_m);
        @(posedge clk); #2;
        rst = 1'b0;
        mem_mode = 0;
        @(posedge clk); #2;
        check("stray_ack_count", 32'(num_buscas), 32'd0);
        check("stray_ack_valid", 32'(instr_valida), 32'd0);
        check("refetch_req", 32'(bus.mem_req), 32'd1);
        check("refetch_addr", 32'(bus.mem_addr), 32'd0);
        wait_valida();
        check("cp_after_reset", 32'(cp), 32'd0);
        repeat (2) @(posedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
